io_write_arbiter: RTL and testbench

IO_WRITE_ARBITER -- requirements
Module: io_write_arbiter

---
 rtl/io_pkg.sv | 26 ++
 rtl/io_rr_arb2.sv | 19 +
 rtl/io_write_arbiter.sv | 84 ++++++++
 tb/tb_io_write_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared FSM encoding, default port map and address decode for the IO write arbiter
package io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    DONE = 2'd2
  } io_state_t;

  localparam logic [5:0] PORT_BASE_DEF = 6'h20;
  localparam int         NUM_PORTS_DEF = 2;

  // Only the word index addr[7:2] selects a port; upper bits are not decoded.
  function automatic logic is_mapped(input logic [31:0] a,
                                     input logic [5:0]  base,
                                     input int          num);
    logic [6:0] idx;
    logic [6:0] lo;
    logic [6:0] hi;
    idx = {1'b0, a[7:2]};
    lo  = {1'b0, base};
    hi  = lo + 7'(num);
    return (idx >= lo) && (idx < hi);
  endfunction

endpackage

// File: rtl/io_rr_arb2.sv
// rtl/io_rr_arb2.sv - two-requester round-robin grant selection
module io_rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant
);

  // On contention favour whoever was not granted last; a lone request always wins.
  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/io_write_arbiter.sv
// rtl/io_write_arbiter.sv - arbitrates two write requesters onto the output-port register bank
module io_write_arbiter
  import io_pkg::*;
#(
  parameter logic [5:0] PORT_BASE = PORT_BASE_DEF,
  parameter int         NUM_PORTS = NUM_PORTS_DEF
) (
  input  logic        io_clk,
  input  logic        clr,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic        ack0,
  output logic        ack1,
  output logic        err,
  output logic [31:0] io_addr,
  output logic [31:0] io_datain,
  output logic        write_io_enable
);

  io_state_t state;
  io_state_t next_state;
  logic      last;
  logic      grant_idx;
  logic      grant_q;
  logic      mapped_q;
  logic      take;

  io_rr_arb2 u_arb (
    .req0  (req0),
    .req1  (req1),
    .last  (last),
    .grant (grant_idx)
  );

  assign take = (state == IDLE) && (req0 || req1);

  always_ff @(posedge io_clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      last      <= 1'b1;
      grant_q   <= 1'b0;
      mapped_q  <= 1'b0;
      io_addr   <= '0;
      io_datain <= '0;
    end else begin
      state <= next_state;
      if (take) begin
        grant_q   <= grant_idx;
        last      <= grant_idx;
        io_addr   <= grant_idx ? addr1 : addr0;
        io_datain <= grant_idx ? data1 : data0;
        mapped_q  <= is_mapped(grant_idx ? addr1 : addr0, PORT_BASE, NUM_PORTS);
      end
    end
  end

  // Outputs decode from state only, so clearing state silences them immediately.
  always_comb begin
    next_state      = state;
    write_io_enable = 1'b0;
    ack0            = 1'b0;
    ack1            = 1'b0;
    err             = 1'b0;
    case (state)
      IDLE: if (take) next_state = WR;
      WR: begin
        write_io_enable = mapped_q;
        next_state      = DONE;
      end
      DONE: begin
        ack0       = ~grant_q;
        ack1       = grant_q;
        err        = ~mapped_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_io_write_arbiter.sv
// tb/tb_io_write_arbiter.sv - directed table-driven bench for io_write_arbiter
module tb_io_write_arbiter;

  logic        io_clk = 1'b0;
  logic        clr;
  logic        req0, req1;
  logic [31:0] addr0, addr1, data0, data1;
  logic        ack0, ack1, err;
  logic [31:0] io_addr, io_datain;
  logic        write_io_enable;

  int checks   = 0;
  int failures = 0;

  io_write_arbiter dut (
    .io_clk          (io_clk),
    .clr             (clr),
    .req0            (req0),
    .req1            (req1),
    .addr0           (addr0),
    .addr1           (addr1),
    .data0           (data0),
    .data1           (data1),
    .ack0            (ack0),
    .ack1            (ack1),
    .err             (err),
    .io_addr         (io_addr),
    .io_datain       (io_datain),
    .write_io_enable (write_io_enable)
  );

  always #5 io_clk = ~io_clk;

  typedef struct {
    logic        r0;
    logic        r1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        g;
    logic        we;
    logic        e;
    logic [31:0] ea;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge io_clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    req0  = vecs[i].r0;
    req1  = vecs[i].r1;
    addr0 = vecs[i].a0;
    addr1 = vecs[i].a1;
    data0 = vecs[i].d0;
    data1 = vecs[i].d1;
    step();
    chk($sformatf("v%0d_wr_we", i), 32'(write_io_enable), 32'(vecs[i].we));
    chk($sformatf("v%0d_wr_addr", i), io_addr, vecs[i].ea);
    chk($sformatf("v%0d_wr_data", i), io_datain, vecs[i].ed);
    chk($sformatf("v%0d_wr_acks", i), {30'd0, ack1, ack0}, 32'd0);
    step();
    chk($sformatf("v%0d_done_acks", i), {30'd0, ack1, ack0}, {30'd0, vecs[i].g, ~vecs[i].g});
    chk($sformatf("v%0d_done_err", i), 32'(err), 32'(vecs[i].e));
    chk($sformatf("v%0d_done_we", i), 32'(write_io_enable), 32'd0);
    chk($sformatf("v%0d_done_addr", i), io_addr, vecs[i].ea);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
  endtask

  initial begin
    int ack_cyc[4];
    logic ack_who[4];
    int n;

    //         r0    r1    a0             a1            d0             d1            g     we    e     ea             ed
    vecs[0] = '{1'b1, 1'b0, 32'h80,        32'h0,        32'hA5A5_0001, 32'h0,        1'b0, 1'b1, 1'b0, 32'h80,        32'hA5A5_0001};
    vecs[1] = '{1'b0, 1'b1, 32'h0,         32'h84,       32'h0,         32'h1234,     1'b1, 1'b1, 1'b0, 32'h84,        32'h1234};
    vecs[2] = '{1'b0, 1'b1, 32'h0,         32'h88,       32'h0,         32'hDEAD,     1'b1, 1'b0, 1'b1, 32'h88,        32'hDEAD};
    vecs[3] = '{1'b1, 1'b1, 32'h84,        32'h80,       32'h11,        32'h22,       1'b0, 1'b1, 1'b0, 32'h84,        32'h11};
    vecs[4] = '{1'b1, 1'b1, 32'h84,        32'h80,       32'h11,        32'h22,       1'b1, 1'b1, 1'b0, 32'h80,        32'h22};
    vecs[5] = '{1'b1, 1'b0, 32'h7C,        32'h0,        32'h55,        32'h0,        1'b0, 1'b0, 1'b1, 32'h7C,        32'h55};
    vecs[6] = '{1'b1, 1'b0, 32'h1000_0080, 32'h0,        32'h66,        32'h0,        1'b0, 1'b1, 1'b0, 32'h1000_0080, 32'h66};
    vecs[7] = '{1'b1, 1'b1, 32'h8C,        32'h84,       32'h77,        32'h88,       1'b1, 1'b1, 1'b0, 32'h84,        32'h88};

    clr = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    repeat (2) step();
    chk("rst_acks", {30'd0, ack1, ack0}, 32'd0);
    chk("rst_err_we", {30'd0, err, write_io_enable}, 32'd0);
    chk("rst_io_addr", io_addr, 32'd0);
    chk("rst_io_datain", io_datain, 32'd0);
    clr = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Inputs changed during WR must not affect the granted write.
    req0 = 1'b1; addr0 = 32'h80; data0 = 32'hAAAA;
    step();
    addr0 = 32'h88; data0 = 32'hBBBB; req1 = 1'b1; addr1 = 32'h84;
    chk("ign_we", 32'(write_io_enable), 32'd1);
    chk("ign_addr", io_addr, 32'h80);
    chk("ign_data", io_datain, 32'hAAAA);
    step();
    chk("ign_ack0", {30'd0, ack1, ack0}, 32'd1);
    chk("ign_err", 32'(err), 32'd0);
    chk("ign_hold", io_datain, 32'hAAAA);
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Request dropped in WR, then clr pulsed in DONE.
    req1 = 1'b1; addr1 = 32'h84; data1 = 32'h4321;
    step();
    req1 = 1'b0;
    chk("clr_wr_we", 32'(write_io_enable), 32'd1);
    step();
    chk("clr_done_ack1", 32'(ack1), 32'd1);
    clr = 1'b1;
    #1;
    chk("clr_acks", {30'd0, ack1, ack0}, 32'd0);
    chk("clr_err_we", {30'd0, err, write_io_enable}, 32'd0);
    chk("clr_io_addr", io_addr, 32'd0);
    chk("clr_io_datain", io_datain, 32'd0);
    step();
    clr = 1'b0;
    step();
    chk("post_clr_idle", {29'd0, write_io_enable, ack1, ack0}, 32'd0);

    // Continuous contention: expect grants 0,1,0,1 spaced 3 cycles apart.
    req0 = 1'b1; req1 = 1'b1;
    addr0 = 32'h80; addr1 = 32'h84; data0 = 32'h1; data1 = 32'h2;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      step();
      chk("cont_excl", 32'((ack0 && ack1) || (write_io_enable && (ack0 || ack1))), 32'd0);
      if (ack0 || ack1) begin
        ack_cyc[n] = c;
        ack_who[n] = ack1;
        n++;
      end
    end
    chk("cont_count", 32'(n), 32'd4);
    if (n == 4) begin
      chk("cont_g0", 32'(ack_who[0]), 32'd0);
      chk("cont_g1", 32'(ack_who[1]), 32'd1);
      chk("cont_g2", 32'(ack_who[2]), 32'd0);
      chk("cont_g3", 32'(ack_who[3]), 32'd1);
      chk("cont_first", 32'(ack_cyc[0]), 32'd1);
      chk("cont_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
      chk("cont_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd3);
      chk("cont_gap3", 32'(ack_cyc[3] - ack_cyc[2]), 32'd3);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
